// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, widths and constants for the Pong match controller.
package pong_pkg;
  localparam int STATE_W = 3;
  localparam int SCORE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    OVER  = 3'd4
  } state_e;
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic SERVE_TO_P1 = 1'b0;
  localparam logic SERVE_TO_P2 = 1'b1;
  localparam logic [SCORE_W-1:0] BLANK_DIGIT = 4'hF;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? s : s + 1'b1;
  endfunction
endpackage

// File: rtl/pong_match_ctrl_frame_timer.sv
// frame_timer: counts animate strobes from a load and flags the strobe that reaches the target.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_animate,
  input  logic [W-1:0] i_target,
  output logic         o_done
);
  logic [W-1:0] count_q, count_d;
  assign count_d = i_load ? '0 : i_animate ? count_q + 1'b1 : count_q;
  assign o_done = i_animate && (count_q + 1'b1 == i_target);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer (serve delay, goal pause, win detection) for two-player Pong.
// Optional PONG_BLINK_EN: blink the winner's digit in OVER every 16 animate frames.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_FRAMES  = 90,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_animate,
  input  logic               i_start_btn,
  input  logic               i_goal_player_1,
  input  logic               i_goal_player_2,
  output logic [SCORE_W-1:0] o_score_player_1,
  output logic [SCORE_W-1:0] o_score_player_2,
  output logic               o_ball_run,
  output logic               o_paddle_en,
  output logic               o_ball_reset,
  output logic               o_serve_dir,
  output logic [1:0]         o_winner,
  output logic [STATE_W-1:0] o_state
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_e state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic serve_dir_q, serve_dir_d;
  logic [1:0] winner_q, winner_d;
  logic btn_q, start_q, done;
  logic [FRAME_CNT_W-1:0] target;
  // One timer serves both the serve delay and the goal pause; it restarts on every state change.
  assign target = (state_q == GOAL) ? FRAME_CNT_W'(GOAL_FRAMES) : FRAME_CNT_W'(SERVE_FRAMES);
  frame_timer #(.W(FRAME_CNT_W)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (state_d != state_q),
    .i_animate (i_animate),
    .i_target  (target),
    .o_done    (done)
  );
  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      IDLE, OVER: if (start_q) begin
        state_d     = SERVE;
        score1_d    = '0;
        score2_d    = '0;
        serve_dir_d = SERVE_TO_P1;
        winner_d    = WINNER_NONE;
      end
      SERVE: state_d = done ? PLAY : SERVE;
      PLAY: if (i_goal_player_1 || i_goal_player_2) begin
        state_d = GOAL;
        if (i_goal_player_1 && !i_goal_player_2) begin
          score1_d    = sat_inc(score1_q, WIN);
          serve_dir_d = SERVE_TO_P2;
        end else if (i_goal_player_2 && !i_goal_player_1) begin
          score2_d    = sat_inc(score2_q, WIN);
          serve_dir_d = SERVE_TO_P1;
        end
      end
      GOAL: if (done) begin
        state_d  = (score1_q == WIN || score2_q == WIN) ? OVER : SERVE;
        winner_d = (score1_q == WIN) ? WINNER_P1 : (score2_q == WIN) ? WINNER_P2 : WINNER_NONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // btn_q starts at 1 so a button held through reset must be released before it can start a match.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_dir_q <= SERVE_TO_P1;
      winner_q    <= WINNER_NONE;
      btn_q       <= 1'b1;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      btn_q       <= i_start_btn;
      start_q     <= i_start_btn && !btn_q;
    end
  end
  assign o_ball_run   = (state_q == PLAY);
  assign o_paddle_en  = (state_q == SERVE) || (state_q == PLAY);
  assign o_ball_reset = (state_q == IDLE) || (state_q == SERVE) || (state_q == OVER);
  assign o_serve_dir  = serve_dir_q;
  assign o_winner     = winner_q;
  assign o_state      = state_q;
`ifdef PONG_BLINK_EN
  logic [3:0] blink_q;
  logic blank_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else if (state_q != OVER) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else if (i_animate) begin
      blink_q <= blink_q + 1'b1;
      blank_q <= (blink_q == 4'hF) ? !blank_q : blank_q;
    end
  end
  assign o_score_player_1 = (state_q == OVER && blank_q && winner_q == WINNER_P1) ? BLANK_DIGIT : score1_q;
  assign o_score_player_2 = (state_q == OVER && blank_q && winner_q == WINNER_P2) ? BLANK_DIGIT : score2_q;
`else
  assign o_score_player_1 = score1_q;
  assign o_score_player_2 = score2_q;
`endif
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed stimulus with a frame-level match model checked every cycle.
module tb_pong_match_ctrl;
  localparam int WIN = 2;
  localparam int SF  = 3;
  localparam int GF  = 2;
  logic clk = 1'b0, rst = 1'b1, anim = 1'b0, btn = 1'b1, g1 = 1'b0, g2 = 1'b0;
  logic [3:0] s1_o, s2_o;
  logic run_o, pad_o, brst_o, dir_o;
  logic [1:0] win_o;
  logic [2:0] st_o;
  int n_tests = 0, n_fail = 0;
  int m_state, m_cnt, m_s1, m_s2, m_dir, m_win, m_blink;
  bit m_btn, m_go;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .GOAL_FRAMES(GF), .FRAME_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_animate(anim), .i_start_btn(btn),
    .i_goal_player_1(g1), .i_goal_player_2(g2),
    .o_score_player_1(s1_o), .o_score_player_2(s2_o),
    .o_ball_run(run_o), .o_paddle_en(pad_o), .o_ball_reset(brst_o),
    .o_serve_dir(dir_o), .o_winner(win_o), .o_state(st_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0; m_blink = 0;
    m_btn = 1'b1; m_go = 1'b0;
  endtask

  // States: 0 idle, 1 serve, 2 play, 3 goal, 4 over; called once per rising edge.
  task automatic model_step();
    bit st;
    st = m_go;
    m_go = btn && !m_btn;
    m_btn = btn;
    if (m_state == 4 && anim) m_blink = m_blink + 1;
    case (m_state)
      0, 4: if (st) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_state = 1; m_cnt = 0;
      end
      1: if (anim) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == SF) begin m_state = 2; m_cnt = 0; end
      end
      2: if (g1 || g2) begin
        if (g1 && !g2) begin m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1; m_dir = 1; end
        if (g2 && !g1) begin m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2; m_dir = 0; end
        m_state = 3; m_cnt = 0;
      end
      3: if (anim) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == GF) begin
          m_cnt = 0;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_win = (m_s1 == WIN) ? 1 : 2; m_state = 4; m_blink = 0;
          end else m_state = 1;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  always @(negedge clk) begin
    logic [16:0] exp_v, act_v;
    int e1, e2;
    e1 = m_s1; e2 = m_s2;
`ifdef PONG_BLINK_EN
    if (m_state == 4 && ((m_blink / 16) % 2 == 1)) begin
      if (m_win == 1) e1 = 15;
      else e2 = 15;
    end
`endif
    exp_v = {3'(m_state), 4'(e1), 4'(e2), m_state == 2, m_state == 1 || m_state == 2,
             m_state == 0 || m_state == 1 || m_state == 4, 1'(m_dir), 2'(m_win)};
    act_v = {st_o, s1_o, s2_o, run_o, pad_o, brst_o, dir_o, win_o};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit a, input bit p1, input bit p2);
    @(negedge clk);
    anim = a; g1 = p1; g2 = p2;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic anims(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
  endtask

  task automatic start_edge();
    btn = 1'b0; cyc(0, 0, 0); cyc(0, 0, 0);
    btn = 1'b1; cyc(0, 0, 0); cyc(0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) cyc(0, 0, 0);
    chk("idle_after_reset_btn_held", int'(st_o), 0);
    btn = 1'b0; cyc(0, 0, 0); cyc(0, 0, 0);
    chk("still_idle_btn_low", int'(st_o), 0);
    btn = 1'b1; cyc(0, 0, 0);
    chk("idle_one_cycle_after_edge", int'(st_o), 0);
    cyc(0, 0, 0);
    chk("serve_two_cycles_after_edge", int'(st_o), 1);
    chk("serve_scores", int'({s1_o, s2_o}), 0);
    anims(2);
    cyc(1, 0, 0);
    chk("play_after_third_anim", int'(st_o), 2);
    chk("play_ball_run_reset", int'({run_o, brst_o}), 2);
    cyc(0, 1, 0);
    chk("p1_goal_state", int'(st_o), 3);
    chk("p1_goal_score", int'(s1_o), 1);
    chk("p1_goal_dir", int'(dir_o), 1);
    cyc(0, 1, 0); cyc(0, 0, 1);
    chk("goal_ignored_in_goal", int'({s1_o, s2_o}), 8'h10);
    anims(GF);
    chk("goal_to_serve", int'(st_o), 1);
    cyc(0, 0, 1);
    chk("goal_ignored_in_serve", int'(s2_o), 0);
    anims(SF);
    cyc(0, 1, 1);
    chk("dual_goal_state", int'(st_o), 3);
    chk("dual_goal_scores", int'({s1_o, s2_o}), 8'h10);
    chk("dual_goal_dir", int'(dir_o), 1);
    anims(GF); anims(SF);
    cyc(0, 0, 1);
    chk("p2_goal_dir", int'(dir_o), 0);
    anims(GF); anims(SF);
    cyc(0, 0, 1);
    chk("p2_second_goal", int'(s2_o), 2);
    anims(GF);
    chk("over_state", int'(st_o), 4);
    chk("over_winner", int'(win_o), 2);
    cyc(0, 1, 0);
    anims(40);
    chk("over_hold_state", int'(st_o), 4);
    start_edge();
    chk("restart_state", int'(st_o), 1);
    chk("restart_scores", int'({s1_o, s2_o}), 0);
    chk("restart_winner", int'(win_o), 0);
    anims(SF);
    cyc(0, 1, 0);
    anims(GF); anims(SF);
    chk("replay_play", int'(st_o), 2);
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_state", int'(st_o), 0);
    chk("async_rst_score", int'(s1_o), 0);
    chk("async_rst_run_reset", int'({run_o, brst_o}), 1);
    @(negedge clk) rst = 1'b0;
    repeat (3) cyc(0, 0, 0);
    chk("no_start_after_rst_btn_held", int'(st_o), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Game-flow sequencer for the two-player VGA Pong design.
- Sits between the frame-rate animate strobe, the ball's goal outputs and the start button.
- Owns match state and both scores.
- Drives the ball/paddle run-enables, the ball re-centre pulse, serve direction and the seven-segment score inputs.
- Replaces free-running scoring with serve delays, goal pauses and a win condition.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_FRAMES, 60, animate frames the ball is held at centre before launch; must be ≥1.
- GOAL_FRAMES, 90, animate frames frozen after a goal; must be ≥1.
- FRAME_CNT_W, 8, width of the internal frame counter; must hold max(SERVE_FRAMES, GOAL_FRAMES).

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  reset, asynchronous, active-high.
- i_animate  in  1  one-cycle pulse, once per frame (end of visible area).
- i_start_btn  in  1  start request, level; already synchronised and debounced.
- i_goal_player_1  in  1  one-cycle pulse: player 1 scored.
- i_goal_player_2  in  1  one-cycle pulse: player 2 scored.
- o_score_player_1  out  4  player 1 score, binary.
- o_score_player_2  out  4  player 2 score, binary.
- o_ball_run  out  1  ball may move this frame.
- o_paddle_en  out  1  paddles accept input.
- o_ball_reset  out  1  ball forced to centre while high.
- o_serve_dir  out  1  0 = serve toward player 1 (y increasing), 1 = toward player 2.
- o_winner  out  2  00 none, 01 player 1, 10 player 2.
- o_state  out  3  current state encoding, for debug/LEDs.

Behaviour:
- States and encodings: IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4. Encodings 5..7 are illegal and recover to IDLE on the next clock.
- Reset (async, any time, including mid-state): state=IDLE, scores=0, frame counter=0, o_serve_dir=0, o_winner=00. The start-edge register is loaded with 1, so a button held through reset does not start a match.
- Start edge: i_start_btn rising edge, registered internally; one cycle of latency.
- IDLE:
  - o_ball_reset=1, o_ball_run=0, o_paddle_en=0.
  - On start edge: clear scores, o_winner=00, o_serve_dir=0, go to SERVE.
- SERVE:
  - o_ball_reset=1, o_paddle_en=1, o_ball_run=0.
  - Frame counter loaded with 0 on entry; increments on each i_animate.
  - On the i_animate that brings the count to SERVE_FRAMES, go to PLAY the next cycle.
- PLAY:
  - o_ball_run=1, o_paddle_en=1, o_ball_reset=0.
  - Goal pulse at cycle N: score incremented and state=GOAL visible at N+1.
  - Serve direction is set toward the player who conceded: player 1 scores → o_serve_dir=1; player 2 scores → o_serve_dir=0.
  - Both goal pulses in the same cycle: no score change, o_serve_dir unchanged, go to GOAL (replay).
- GOAL:
  - o_ball_run=0, o_paddle_en=0, o_ball_reset=0 (ball frozen where it exited).
  - Goal inputs ignored.
  - After GOAL_FRAMES animate pulses: if either score == WIN_SCORE, go to OVER and set o_winner; otherwise go to SERVE.
- OVER:
  - o_ball_reset=1, o_ball_run=0, o_paddle_en=0.
  - Scores and o_winner held.
  - On start edge: behave as the IDLE start (clear and go to SERVE).
- Goal pulses outside PLAY are ignored.
- Scores never exceed WIN_SCORE; the increment saturates as a safety net.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- i_animate coincident with a state change is not counted toward the new state; the counter starts at 0 on entry.

Optional Feature:
- Macro: PONG_BLINK_EN.
- Defined: in OVER, the winner's score output alternates between its value and 4'hF (blank code for the seven-segment decoder) every 16 animate frames; the loser's score is steady. A 4-bit blink counter runs only in OVER and resets on entry.
- Undefined: no blink counter; scores are steady in every state.

Decomposition:
- Shared package pong_pkg:
  - state enum (IDLE..OVER) and its width;
  - SCORE_W=4;
  - WINNER_NONE/P1/P2 constants;
  - SERVE_TO_P1/P2 constants;
  - BLANK_DIGIT=4'hF.
- One sub-module, frame_timer:
  - inputs: clock, async reset, load, i_animate;
  - outputs: done when the count reaches a target input;
  - instantiated once and reused by SERVE and GOAL.

Test Plan:
- Reset held with start high, then released → state IDLE, no start until the button falls and rises again; after that edge, state=SERVE 2 cycles later with scores 0/0.
- SERVE_FRAMES=3: three i_animate pulses in SERVE → state=PLAY one cycle after the third pulse; o_ball_reset falls and o_ball_run rises together.
- In PLAY, pulse i_goal_player_1 → score_player_1=1, o_serve_dir=1, state=GOAL next cycle; after GOAL_FRAMES pulses, state=SERVE.
- Goal pulses in SERVE and GOAL, and both goals in the same PLAY cycle → scores unchanged; the dual case still enters GOAL.
- WIN_SCORE=2: player 2 scores twice → OVER with o_winner=10; start edge → scores 0/0, o_winner=00, SERVE.
- Async reset asserted mid-PLAY between clock edges → outputs return to reset values immediately; with PONG_BLINK_EN defined, the winner's digit toggles to 4'hF every 16 frames in OVER.
